fx1_logic_imm_pipe: RTL
=======================

# fx1_logic_imm_pipe

Pipelined, parametrised logical-immediate unit for the SPU FX1 execution pipe, executing the whole AND/OR/XOR immediate family (andbi/andhi/andi, orbi/orhi/ori, xorbi/xorhi/xori) on a DATA_W-bit quadword. It sits between the FX1 issue stage and the register-file writeback arbiter. It provides a valid/ready handshake with full-pipe backpressure, flush of in-flight operations, and an error flag for illegal encodings.

## Interface
- DATA_W, 128, operand/result width; must be a multiple of 32
- IMM_W, 10, immediate width (I10 field)
- LATENCY, 2, pipeline depth in cycles, legal range 1..4
- TAG_W, 7, destination register tag width
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous assert, active-low, synchronously released upstream
- in_valid  in  1  operation offered
- in_ready  out  1  unit accepts the offered operation this cycle
- in_op  in  4  op code: [3:2] element size (00 byte, 01 half, 10 word), [1:0] function (00 AND, 01 OR, 10 XOR)
- in_ra  in  DATA_W  source operand, big-endian bit numbering [0:DATA_W-1], slot 0 at bit 0
- in_imm  in  IMM_W  immediate
- in_tag  in  TAG_W  destination tag, passed through unchanged
- flush  in  1  kill all in-flight operations
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_result  out  DATA_W  result
- out_tag  out  TAG_W  tag of the result
- out_err  out  1  operation had an illegal encoding

## Operation
- Immediate expansion:
  - byte: low 8 bits of imm, no sign extension, replicated DATA_W/8 times
  - half: imm sign-extended to 16 bits, replicated DATA_W/16 times
  - word: imm sign-extended to 32 bits, replicated DATA_W/32 times
- Result is ra op mask, bitwise across the full width.
- Illegal encoding (size 11 or function 11): operation still flows through the pipe with its tag, out_result = 0, out_err = 1.
- Handshake:
  - transfer on in_valid & in_ready, and on out_valid & out_ready
  - stall = out_valid & ~out_ready
  - in_ready = ~stall & ~flush
  - during stall every stage holds its contents
  - out_result, out_tag and out_err stay stable while out_valid & ~out_ready
- Flush clears every stage valid bit at the next edge. An input offered in the same cycle as flush is not accepted. Flush overrides stall.

## Timing
- Reset values: out_valid 0, out_result 0, out_tag 0, out_err 0, all internal valid bits 0. in_ready is 1 when flush = 0.
- Latency: an operation accepted at edge N presents out_valid at edge N+LATENCY when there is no stall. Each stall cycle adds one.
- Throughput: one operation per cycle while out_ready stays 1.
- Stage 1 registers the decoded mask, function, ra, tag and err. The result is computed in the final stage. With LATENCY = 1 the whole computation is done in one registered stage.
- Simultaneous output handshake and new input: the pipe advances with no bubble.
- Reset asserted mid-operation: all in-flight operations are discarded immediately (asynchronous); no output is produced for them.

## Structure
- Package spu_fx1_pkg holds:
  - op field encodings: SZ_BYTE/SZ_HALF/SZ_WORD, FN_AND/FN_OR/FN_XOR
  - an op-valid function
- One combinational sub-module, fx1_imm_expand (in: size, imm; out: DATA_W mask, illegal flag), instantiated once before stage 1.
- Pipeline stages are generated from LATENCY. No memories.

## Test plan
- andhi: ra = 128'h0123_4567_89AB_CDEF_FFFF_0000_AAAA_5555, imm = 10'h3F0 (→16'hFFF0) -> result 128'h0120_4560_89A0_CDE0_FFF0_0000_AAA0_5550, out_valid exactly LATENCY cycles after accept, tag preserved.
- orbi/xori: orbi with imm = 10'h201 sets bit 7 of every byte (low 8 bits = 8'h01, no sign extension); xori with imm = 10'h200 (→32'hFFFF_FE00) applied to all-zero ra gives 128'hFFFFFE00 in each word.
- Backpressure: stream 8 back-to-back ops, hold out_ready = 0 for 3 cycles mid-stream -> in_ready drops, outputs stay stable, all 8 results emerge in order with no loss or duplication.
- Flush: 2 ops in flight plus in_valid = 1 with flush = 1 -> no out_valid for any of the three; the next op completes normally after LATENCY cycles.
- Illegal op: in_op = 4'b1100 -> out_err = 1, out_result = 0, tag preserved. The following legal op has out_err = 0.
- Reset mid-stream with rst_n low for 1 cycle -> out_valid = 0 immediately and no stale results after release. Repeat for LATENCY = 1 and LATENCY = 4.

Source files
------------

// File: rtl/spu_fx1_pkg.sv
// Shared encodings and helpers for the FX1 logical-immediate pipe.
package spu_fx1_pkg;

    // Element size field, in_op[3:2]
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } fx1_sz_e;

    // Function field, in_op[1:0]
    typedef enum logic [1:0] {
        FN_AND  = 2'b00,
        FN_OR   = 2'b01,
        FN_XOR  = 2'b10,
        FN_RSVD = 2'b11
    } fx1_fn_e;

    // An op is legal when neither field uses its reserved code.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op[3:2] != 2'b11) && (op[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/fx1_imm_expand.sv
// Combinational immediate expansion: replicates the I10 field into a
// full-width mask according to the element size.
module fx1_imm_expand
    import spu_fx1_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int IMM_W  = 10
) (
    input  logic [1:0]        size,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] mask,
    output logic              illegal
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] word_s;

    // Bytes take the raw low 8 bits; halves and words are sign-extended.
    assign byte_s = imm[7:0];
    assign half_s = 16'($signed(imm));
    assign word_s = 32'($signed(imm));

    // Select the replicated mask for the requested element size.
    always_comb begin
        mask    = '0;
        illegal = 1'b0;
        case (fx1_sz_e'(size))
            SZ_BYTE: mask = {(DATA_W/8){byte_s}};
            SZ_HALF: mask = {(DATA_W/16){half_s}};
            SZ_WORD: mask = {(DATA_W/32){word_s}};
            default: begin
                mask    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fx1_logic_imm_pipe.sv
// FX1 logical-immediate pipe: AND/OR/XOR with an expanded immediate,
// LATENCY registered stages, valid/ready handshake, flush and error flag.
module fx1_logic_imm_pipe
    import spu_fx1_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int IMM_W   = 10,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_ra,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    // Operand-holding stages ahead of the result stage; with LATENCY = 1 a
    // single dummy slot exists but the result stage is fed from the input.
    localparam int MID_N = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic [DATA_W-1:0] mask_s;
    logic              size_illegal_s;
    logic              dec_err_s;
    logic              stall_s;
    logic              in_ready_s;
    logic              accept_s;

    logic              op_v_q    [MID_N];
    logic              op_v_d    [MID_N];
    logic [DATA_W-1:0] op_ra_q   [MID_N];
    logic [DATA_W-1:0] op_ra_d   [MID_N];
    logic [DATA_W-1:0] op_mask_q [MID_N];
    logic [DATA_W-1:0] op_mask_d [MID_N];
    logic [1:0]        op_fn_q   [MID_N];
    logic [1:0]        op_fn_d   [MID_N];
    logic [TAG_W-1:0]  op_tag_q  [MID_N];
    logic [TAG_W-1:0]  op_tag_d  [MID_N];
    logic              op_err_q  [MID_N];
    logic              op_err_d  [MID_N];

    logic              fin_v_s;
    logic [DATA_W-1:0] fin_ra_s;
    logic [DATA_W-1:0] fin_mask_s;
    logic [1:0]        fin_fn_s;
    logic [TAG_W-1:0]  fin_tag_s;
    logic              fin_err_s;

    logic              out_valid_q,  out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic [TAG_W-1:0]  out_tag_q,    out_tag_d;
    logic              out_err_q,    out_err_d;

    // Illegal encodings produce a zero result regardless of operands.
    function automatic logic [DATA_W-1:0] apply_fn(
        input logic [DATA_W-1:0] ra,
        input logic [DATA_W-1:0] mask,
        input logic [1:0]        fn,
        input logic              err
    );
        logic [DATA_W-1:0] r;
        r = '0;
        if (err) begin
            r = '0;
        end else begin
            case (fx1_fn_e'(fn))
                FN_AND:  r = ra & mask;
                FN_OR:   r = ra | mask;
                FN_XOR:  r = ra ^ mask;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    fx1_imm_expand #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_expand (
        .size    (in_op[3:2]),
        .imm     (in_imm),
        .mask    (mask_s),
        .illegal (size_illegal_s)
    );

    // Handshake: the whole pipe freezes while the result is refused.
    always_comb begin
        stall_s    = out_valid_q & ~out_ready;
        in_ready_s = ~stall_s & ~flush;
        accept_s   = in_valid & in_ready_s;
        dec_err_s  = size_illegal_s | ~op_is_legal(in_op);
    end

    // Source of the result stage: the decoded input or the last operand stage.
    always_comb begin
        if (LATENCY == 1) begin
            fin_v_s    = accept_s;
            fin_ra_s   = in_ra;
            fin_mask_s = mask_s;
            fin_fn_s   = in_op[1:0];
            fin_tag_s  = in_tag;
            fin_err_s  = dec_err_s;
        end else begin
            fin_v_s    = op_v_q[MID_N-1];
            fin_ra_s   = op_ra_q[MID_N-1];
            fin_mask_s = op_mask_q[MID_N-1];
            fin_fn_s   = op_fn_q[MID_N-1];
            fin_tag_s  = op_tag_q[MID_N-1];
            fin_err_s  = op_err_q[MID_N-1];
        end
    end

    // Next-state: flush clears valids, otherwise advance unless stalled.
    always_comb begin
        op_v_d       = op_v_q;
        op_ra_d      = op_ra_q;
        op_mask_d    = op_mask_q;
        op_fn_d      = op_fn_q;
        op_tag_d     = op_tag_q;
        op_err_d     = op_err_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_err_d    = out_err_q;
        if (flush) begin
            for (int i = 0; i < MID_N; i++) begin
                op_v_d[i] = 1'b0;
            end
            out_valid_d = 1'b0;
        end else if (!stall_s) begin
            op_v_d[0]    = accept_s;
            op_ra_d[0]   = in_ra;
            op_mask_d[0] = mask_s;
            op_fn_d[0]   = in_op[1:0];
            op_tag_d[0]  = in_tag;
            op_err_d[0]  = dec_err_s;
            for (int i = 1; i < MID_N; i++) begin
                op_v_d[i]    = op_v_q[i-1];
                op_ra_d[i]   = op_ra_q[i-1];
                op_mask_d[i] = op_mask_q[i-1];
                op_fn_d[i]   = op_fn_q[i-1];
                op_tag_d[i]  = op_tag_q[i-1];
                op_err_d[i]  = op_err_q[i-1];
            end
            out_valid_d  = fin_v_s;
            out_result_d = apply_fn(fin_ra_s, fin_mask_s, fin_fn_s, fin_err_s);
            out_tag_d    = fin_tag_s;
            out_err_d    = fin_err_s;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; reset discards every in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MID_N; i++) begin
                op_v_q[i]    <= 1'b0;
                op_ra_q[i]   <= '0;
                op_mask_q[i] <= '0;
                op_fn_q[i]   <= 2'b00;
                op_tag_q[i]  <= '0;
                op_err_q[i]  <= 1'b0;
            end
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_err_q    <= 1'b0;
        end else begin
            op_v_q       <= op_v_d;
            op_ra_q      <= op_ra_d;
            op_mask_q    <= op_mask_d;
            op_fn_q      <= op_fn_d;
            op_tag_q     <= op_tag_d;
            op_err_q     <= op_err_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_err_q    <= out_err_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_err    = out_err_q;

endmodule
